// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and helpers shared by the
// multi-cycle execute ALU and its mul/div iterator.
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_SUB   = 4'b0001;
   localparam logic [3:0] OP_AND   = 4'b0010;
   localparam logic [3:0] OP_SLT   = 4'b0011;
   localparam logic [3:0] OP_OR    = 4'b0100;
   localparam logic [3:0] OP_SLTU  = 4'b0101;
   localparam logic [3:0] OP_MUL   = 4'b0110;
   localparam logic [3:0] OP_MULHU = 4'b0111;
   localparam logic [3:0] OP_XOR   = 4'b1000;
   localparam logic [3:0] OP_SRL   = 4'b1001;
   localparam logic [3:0] OP_SLL   = 4'b1010;
   localparam logic [3:0] OP_DIV   = 4'b1011;
   localparam logic [3:0] OP_SRA   = 4'b1100;
   localparam logic [3:0] OP_DIVU  = 4'b1101;
   localparam logic [3:0] OP_REM   = 4'b1110;
   localparam logic [3:0] OP_REMU  = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Signed minimum pattern for widths up to 128; callers truncate.
   function automatic logic [127:0] smin_pat(input int w);
      return 128'(1) << (w - 1);
   endfunction

   function automatic logic is_mul(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULHU);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU) ||
             (op == OP_REM) || (op == OP_REMU);
   endfunction

   function automatic logic is_sdiv(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shift-add multiplier and restoring divider
// sharing one 2*WIDTH accumulator and one iteration counter.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] res
);
   localparam int CNT_W = $clog2(WIDTH);

   logic               run_q, run_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, acc_nxt;
   logic [WIDTH-1:0]   dvs_q, dvs_d;
   logic [3:0]         op_q, op_d;
   logic               negq_q, negq_d, negr_q, negr_d;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, addend, sub, quo, rem;
   logic [WIDTH:0]     msum, shf;

   always_comb begin
      a_neg  = is_sdiv(op) && a[WIDTH-1];
      b_neg  = is_sdiv(op) && b[WIDTH-1];
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;
      addend = acc_q[0] ? dvs_q : {WIDTH{1'b0}};
      msum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      // Divider view: high half is the partial remainder.
      shf    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      sub    = shf[WIDTH-1:0] - dvs_q;
      if (is_mul(op_q))
         acc_nxt = {msum, acc_q[WIDTH-1:1]};
      else if (shf >= {1'b0, dvs_q})
         acc_nxt = {sub, acc_q[WIDTH-2:0], 1'b1};
      else
         acc_nxt = {shf[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      quo  = acc_nxt[WIDTH-1:0];
      rem  = acc_nxt[2*WIDTH-1:WIDTH];
      done = run_q && (cnt_q == CNT_W'(WIDTH - 1));
      case (op_q)
         OP_MUL:   res = quo;
         OP_MULHU: res = rem;
         OP_DIV:   res = negq_q ? -quo : quo;
         OP_DIVU:  res = quo;
         OP_REM:   res = negr_q ? -rem : rem;
         OP_REMU:  res = rem;
         default:  res = '0;
      endcase
   end

   always_comb begin
      run_d  = run_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      dvs_d  = dvs_q;
      op_d   = op_q;
      negq_d = negq_q;
      negr_d = negr_q;
      if (start) begin
         run_d  = 1'b1;
         cnt_d  = '0;
         op_d   = op;
         negq_d = a_neg ^ b_neg;
         negr_d = a_neg;
         acc_d  = {{WIDTH{1'b0}}, a_mag};
         dvs_d  = b_mag;
      end else if (run_q) begin
         acc_d = acc_nxt;
         cnt_d = cnt_q + 1'b1;
         if (done)
            run_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q  <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         dvs_q  <= '0;
         op_q   <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
      end else begin
         run_q  <= run_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         dvs_q  <= dvs_d;
         op_q   <= op_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: handshaked execute ALU with registered result/flags
// and an iterative RV32M-style mul/div path.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             lt,
   output logic             ltu,
   output logic             busy
);
   localparam int SHAMT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] S_MIN = WIDTH'(smin_pat(WIDTH));

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d, lt_q, lt_d, ltu_q, ltu_d;
   logic [WIDTH-1:0]   alu_res, md_res;
   logic [SHAMT_W-1:0] shamt;
   logic               lt_c, ltu_c, b_zero, s_ovf, iter;
   logic               md_start, md_done;

   always_comb begin
      shamt  = B[SHAMT_W-1:0];
      lt_c   = $signed(A) < $signed(B);
      ltu_c  = A < B;
      b_zero = (B == '0);
      s_ovf  = (A == S_MIN) && (B == '1);
      // Divide special cases resolve here in one cycle.
      case (alu_ctrl)
         OP_ADD:  alu_res = A + B;
         OP_SUB:  alu_res = A - B;
         OP_AND:  alu_res = A & B;
         OP_SLT:  alu_res = WIDTH'(lt_c);
         OP_OR:   alu_res = A | B;
         OP_SLTU: alu_res = WIDTH'(ltu_c);
         OP_XOR:  alu_res = A ^ B;
         OP_SRL:  alu_res = A >> shamt;
         OP_SLL:  alu_res = A << shamt;
         OP_SRA:  alu_res = $unsigned($signed(A) >>> shamt);
         OP_DIV:  alu_res = b_zero ? '1 : S_MIN;
         OP_DIVU: alu_res = '1;
         OP_REM:  alu_res = b_zero ? A : '0;
         OP_REMU: alu_res = A;
         default: alu_res = '0;
      endcase
      iter = is_mul(alu_ctrl) ||
             (is_div(alu_ctrl) && !b_zero &&
              !(is_sdiv(alu_ctrl) && s_ovf));
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      lt_d     = lt_q;
      ltu_d    = ltu_q;
      md_start = 1'b0;
      case (state_q)
         ST_IDLE: if (in_valid) begin
            lt_d  = lt_c;
            ltu_d = ltu_c;
            if (iter) begin
               md_start = 1'b1;
               state_d  = ST_BUSY;
            end else begin
               result_d = alu_res;
               zero_d   = (alu_res == '0);
               state_d  = ST_DONE;
            end
         end
         ST_BUSY: if (md_done) begin
            result_d = md_res;
            zero_d   = (md_res == '0);
            state_d  = ST_DONE;
         end
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         lt_q     <= 1'b0;
         ltu_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         lt_q     <= lt_d;
         ltu_q    <= ltu_d;
      end
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk   (clk),
      .rst_n (rst_n),
      .start (md_start),
      .op    (alu_ctrl),
      .a     (A),
      .b     (B),
      .done  (md_done),
      .res   (md_res)
   );

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_BUSY);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign lt        = lt_q;
   assign ltu       = ltu_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, handshaked successor to the single-cycle execute ALU.
- Width-generic integer ALU with registered output.
- Adds SLT/SLTU, true operand-based lt/ltu flags, and iterative MUL/MULHU/DIV/DIVU/REM/REMU (RV32M subset).
- Sits in the execute stage between operand mux and writeback; stalls the pipe via valid/ready while iterating.

Parameters:
- WIDTH, 32: operand/result width; must be a power of two, at least 8.
- SHAMT_W, $clog2(WIDTH): derived localparam, not overridable. Shift amount = B[SHAMT_W-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block can accept; high only in IDLE
- alu_ctrl  in  4  operation code
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- zero  out  1  result == 0, registered with result
- lt  out  1  signed A < B, registered
- ltu  out  1  unsigned A < B, registered
- busy  out  1  iterative op in progress

Behaviour:
- Opcodes:
  - ADD 0000, SUB 0001, AND 0010, SLT 0011, OR 0100, SLTU 0101, MUL 0110, MULHU 0111
  - XOR 1000, SRL 1001, SLL 1010, DIV 1011, SRA 1100, DIVU 1101, REM 1110, REMU 1111
  - Encodings of the legacy ops are unchanged.
- Reset (rst_n low at a clk edge): state = IDLE; result = 0, zero = 0, lt = 0, ltu = 0; out_valid = 0, busy = 0; counter and working registers cleared. Reset mid-operation aborts the op and produces no output.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. On in_valid, capture the op; lt/ltu are computed from A/B at capture.
    - Single-cycle op, or MUL/DIV special case: go to DONE (latency 1 cycle).
    - Otherwise: go to BUSY with count = 0.
  - BUSY: busy = 1, in_ready = 0. One iteration per cycle. After WIDTH iterations, go to DONE. Total accept-to-out_valid latency = WIDTH+1 cycles.
  - DONE: out_valid = 1. result and flags are held stable until out_ready. On out_ready, go to IDLE. No new op is accepted in the same cycle, giving 1 bubble.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SLT/SLTU: result = {0..., lt} or {0..., ltu}.
  - SRA is arithmetic, using the shift-amount mask above. SRL/SLL are logical.
  - Undefined opcodes do not exist; all 16 codes are defined. Result is never X or Z.
- MUL/MULHU:
  - Unsigned shift-add over a 2*WIDTH product register.
  - MUL returns the low WIDTH bits; this is identical for signed operands.
  - MULHU returns the high WIDTH bits.
- DIV/DIVU/REM/REMU:
  - Restoring division on magnitudes. Sign fix-up is applied in the final BUSY cycle: the quotient is negated if the operand signs differ; the remainder takes the sign of A.
- Divide special cases, resolved in IDLE with 1-cycle latency:
  - B == 0: quotient = all ones; remainder = A.
  - Signed A == MIN and B == -1: quotient = MIN; remainder = 0.
- Flags:
  - zero reflects the final result.
  - lt/ltu are operand comparisons for every op, not a result sign.
- Inputs are ignored while in_ready = 0. A/B changing during BUSY has no effect.

Decomposition:
- Shared package alu_pkg holds:
  - the 16 opcode localparams
  - state encoding localparams
  - helper constants (signed MIN pattern)
- One sub-module: alu_muldiv_iter (shift-add multiplier + restoring divider, shared counter, start/done). alu_mc keeps the FSM, the combinational single-cycle datapath and the output registers.

Test Plan (WIDTH = 32):
- ADD: A = 0x7FFFFFFF, B = 1 -> 1 cycle later out_valid, result = 0x80000000, zero = 0, lt = 0, ltu = 0. SUB: A = 5, B = 5 -> result 0, zero = 1.
- SRA: A = 0x80000000, B = 0x00000024 (amount 4) -> 0xF8000000. SLTU: A = 1, B = 0xFFFFFFFF -> result 1, ltu = 1, lt = 0.
- MULHU: A = B = 0xFFFFFFFF -> out_valid exactly 33 cycles after accept, result 0xFFFFFFFE. MUL: same operands -> 0x00000001. busy = 1 for 32 cycles.
- DIV: A = -7, B = 2 -> quotient 0xFFFFFFFD. REM: same operands -> 0xFFFFFFFF. DIVU: A = 0x80000000, B = 0 -> 0xFFFFFFFF at 1-cycle latency. DIV: A = 0x80000000, B = -1 -> 0x80000000.
- Backpressure: hold out_ready = 0 for 5 cycles after DONE -> result stable, in_ready = 0, a new in_valid is ignored. Then out_ready = 1 -> IDLE, next op accepted the cycle after.
- Reset: assert rst_n = 0 mid-DIVU at count 10 -> next cycle state IDLE, out_valid = 0, result = 0. A fresh ADD afterwards completes normally.
